// File: rtl/mips_defs.sv
// Shared definitions for the multicycle MIPS-subset CPU: opcodes, function
// codes, ALU operation codes, control-state encodings and datapath select codes.
package mips_defs;

    localparam int PC_INC = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_HAM = 6'b111111;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_HAM = 4'b1011;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_PCINC  = 2'b01;
    localparam logic [1:0] SRCB_EXT    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_REGA   = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/func to one-hot instruction class,
// the ALU code used in EXE, and the shift/sign-extension qualifiers.
module mc_decode
    import mips_defs::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic       rtype,
    output logic       itype_alu,
    output logic       load,
    output logic       store,
    output logic       branch,
    output logic       jump,
    output logic       illegal,
    output logic       shift_op,
    output logic       sext_imm,
    output logic [3:0] exe_aluc
);

    always_comb begin
        rtype     = 1'b0;
        itype_alu = 1'b0;
        load      = 1'b0;
        store     = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        illegal   = 1'b0;
        shift_op  = 1'b0;
        sext_imm  = 1'b0;
        exe_aluc  = ALUC_ADD;
        case (op)
            OP_RTYPE: begin
                rtype = 1'b1;
                case (func)
                    F_ADD: exe_aluc = ALUC_ADD;
                    F_SUB: exe_aluc = ALUC_SUB;
                    F_AND: exe_aluc = ALUC_AND;
                    F_OR:  exe_aluc = ALUC_OR;
                    F_XOR: exe_aluc = ALUC_XOR;
                    F_HAM: exe_aluc = ALUC_HAM;
                    F_SLL: begin exe_aluc = ALUC_SLL; shift_op = 1'b1; end
                    F_SRL: begin exe_aluc = ALUC_SRL; shift_op = 1'b1; end
                    F_SRA: begin exe_aluc = ALUC_SRA; shift_op = 1'b1; end
                    // jr shares the R-type opcode but completes in ID like a jump
                    F_JR:  begin rtype = 1'b0; jump = 1'b1; end
                    default: begin rtype = 1'b0; illegal = 1'b1; end
                endcase
            end
            OP_ADDI: begin itype_alu = 1'b1; sext_imm = 1'b1; exe_aluc = ALUC_ADD; end
            OP_ANDI: begin itype_alu = 1'b1; exe_aluc = ALUC_AND; end
            OP_ORI:  begin itype_alu = 1'b1; exe_aluc = ALUC_OR;  end
            OP_XORI: begin itype_alu = 1'b1; exe_aluc = ALUC_XOR; end
            OP_LUI:  begin itype_alu = 1'b1; exe_aluc = ALUC_LUI; end
            OP_LW:   begin load  = 1'b1; sext_imm = 1'b1; end
            OP_SW:   begin store = 1'b1; sext_imm = 1'b1; end
            OP_BEQ, OP_BNE: begin branch = 1'b1; exe_aluc = ALUC_SUB; end
            OP_J, OP_JAL:   jump = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle control unit: sequences IF/ID/EXE/MEM/WB and drives the ALU code,
// datapath selects and write enables, all combinational from state, op, func, z.
module mc_control
    import mips_defs::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic [3:0] aluc,
    output logic       alusrca,
    output logic       shift,
    output logic [1:0] alusrcb,
    output logic       sext,
    output logic [1:0] pcsrc,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       illegal,
    output logic [2:0] state
);

    state_t state_reg, state_next;
    logic rtype, itype_alu, load, store, branch, jump, dec_illegal, shift_op, sext_imm;
    logic [3:0] exe_aluc;
    logic wpc_dec, wir_dec, wmem_dec, wreg_dec, illegal_dec;

    mc_decode u_decode (
        .op        (op),
        .func      (func),
        .rtype     (rtype),
        .itype_alu (itype_alu),
        .load      (load),
        .store     (store),
        .branch    (branch),
        .jump      (jump),
        .illegal   (dec_illegal),
        .shift_op  (shift_op),
        .sext_imm  (sext_imm),
        .exe_aluc  (exe_aluc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= S_IF;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = S_IF;
        case (state_reg)
            S_IF:  state_next = S_ID;
            S_ID:  state_next = (jump || dec_illegal) ? S_IF : S_EXE;
            S_EXE: state_next = branch ? S_IF : ((load || store) ? S_MEM : S_WB);
            S_MEM: state_next = store ? S_IF : S_WB;
            default: state_next = S_IF;
        endcase
    end

    always_comb begin
        wpc_dec     = 1'b0;
        wir_dec     = 1'b0;
        wmem_dec    = 1'b0;
        wreg_dec    = 1'b0;
        illegal_dec = 1'b0;
        iord        = 1'b0;
        aluc        = ALUC_ADD;
        alusrca     = 1'b0;
        shift       = 1'b0;
        alusrcb     = SRCB_REGB;
        sext        = 1'b0;
        pcsrc       = PCSRC_ALU;
        regrt       = 1'b0;
        m2reg       = 1'b0;
        jal         = 1'b0;
        case (state_reg)
            S_IF: begin
                wir_dec = 1'b1;
                wpc_dec = 1'b1;
                alusrcb = SRCB_PCINC;
            end
            S_ID: begin
                // Branch target is computed here regardless of instruction class
                alusrcb = SRCB_BRANCH;
                sext    = 1'b1;
                if (dec_illegal) begin
                    illegal_dec = 1'b1;
                end else if (jump) begin
                    wpc_dec = 1'b1;
                    pcsrc   = (op == OP_RTYPE) ? PCSRC_REGA : PCSRC_JUMP;
                    if (op == OP_JAL) begin
                        jal      = 1'b1;
                        wreg_dec = 1'b1;
                    end
                end
            end
            S_EXE: begin
                aluc = exe_aluc;
                if (branch) begin
                    alusrca = 1'b1;
                    pcsrc   = PCSRC_ALUOUT;
                    wpc_dec = (op == OP_BEQ) ? z : ~z;
                end else if (rtype) begin
                    alusrca = 1'b1;
                    shift   = shift_op;
                end else if (itype_alu || load || store) begin
                    alusrcb = SRCB_EXT;
                    sext    = sext_imm;
                end
            end
            S_MEM: begin
                iord     = 1'b1;
                wmem_dec = store;
            end
            S_WB: begin
                wreg_dec = 1'b1;
                regrt    = itype_alu || load;
                m2reg    = load;
            end
            default: ;
        endcase
    end

    // Reset suppresses every write combinationally so an aborted instruction commits nothing
    assign wpc     = wpc_dec & ~reset;
    assign wir     = wir_dec & ~reset;
    assign wmem    = wmem_dec & ~reset;
    assign wreg    = wreg_dec & ~reset;
    assign illegal = illegal_dec & ~reset;
    assign state   = state_reg;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: each driven cycle queues the expected control
// vector; a negedge monitor pops and compares it against the DUT outputs.
module tb_mc_control;

    typedef struct packed {
        logic       wpc, wir, wmem, wreg, iord;
        logic [3:0] aluc;
        logic       alusrca, shift;
        logic [1:0] alusrcb;
        logic       sext;
        logic [1:0] pcsrc;
        logic       regrt, m2reg, jal, illegal;
        logic [2:0] state;
    } outv_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0, func = 6'd0;
    logic       z = 1'b0;
    logic       wpc, wir, wmem, wreg, iord, alusrca, shift, sext, regrt, m2reg, jal, illegal;
    logic [3:0] aluc;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    outv_t exp_q[$];
    string name_q[$];

    mc_control dut (
        .clock(clock), .reset(reset), .op(op), .func(func), .z(z),
        .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord),
        .aluc(aluc), .alusrca(alusrca), .shift(shift), .alusrcb(alusrcb),
        .sext(sext), .pcsrc(pcsrc), .regrt(regrt), .m2reg(m2reg),
        .jal(jal), .illegal(illegal), .state(state)
    );

    always #5 clock = ~clock;

    function automatic outv_t v_state(input logic [2:0] s);
        outv_t e;
        e = '0;
        e.state = s;
        return e;
    endfunction

    function automatic outv_t v_if();
        outv_t e;
        e = v_state(3'd0);
        e.wir = 1'b1; e.wpc = 1'b1; e.alusrcb = 2'b01;
        return e;
    endfunction

    function automatic outv_t v_rst();
        outv_t e;
        e = v_if();
        e.wir = 1'b0; e.wpc = 1'b0;
        return e;
    endfunction

    function automatic outv_t v_id();
        outv_t e;
        e = v_state(3'd1);
        e.alusrcb = 2'b11; e.sext = 1'b1;
        return e;
    endfunction

    function automatic outv_t v_wb(input logic rt, input logic mr);
        outv_t e;
        e = v_state(3'd4);
        e.wreg = 1'b1; e.regrt = rt; e.m2reg = mr;
        return e;
    endfunction

    task automatic step(input string nm, input logic [5:0] o, input logic [5:0] f,
                        input logic zz, input outv_t e);
        @(posedge clock);
        #1;
        op = o; func = f; z = zz;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic rst_step(input string nm, input logic r);
        @(posedge clock);
        #1;
        reset = r;
        exp_q.push_back(r ? v_rst() : v_if());
        name_q.push_back(nm);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            outv_t e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {wpc, wir, wmem, wreg, iord, aluc, alusrca, shift, alusrcb, sext,
                  pcsrc, regrt, m2reg, jal, illegal, state};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s actual=%06h required=%06h (state %0d vs %0d)",
                         nm, a, e, a.state, e.state);
            end else begin
                $display("ok   %s state=%0d", nm, a.state);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        outv_t e;

        // Power-up reset then release
        rst_step("reset_hold0", 1'b1);
        rst_step("reset_hold1", 1'b1);
        rst_step("reset_release_if", 1'b0);

        // add interrupted by reset in EXE
        step("add_id", 6'b000000, 6'b100000, 1'b0, v_id());
        e = v_state(3'd2); e.alusrca = 1'b1;
        step("add_exe", 6'b000000, 6'b100000, 1'b0, e);
        #6;
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || wreg !== 1'b0 || wpc !== 1'b0) begin
            errors++;
            $display("FAIL abort_exe actual=state%0d/wreg%b/wpc%b required=state0/wreg0/wpc0",
                     state, wreg, wpc);
        end
        rst_step("abort_hold0", 1'b1);
        rst_step("abort_hold1", 1'b1);
        rst_step("abort_hold2", 1'b1);
        rst_step("abort_release_if", 1'b0);

        // add complete: 4 cycles
        step("add_id", 6'b000000, 6'b100000, 1'b0, v_id());
        e = v_state(3'd2); e.alusrca = 1'b1;
        step("add_exe", 6'b000000, 6'b100000, 1'b1, e);
        step("add_wb", 6'b000000, 6'b100000, 1'b0, v_wb(1'b0, 1'b0));

        // sra
        step("sra_if", 6'b000000, 6'b000011, 1'b0, v_if());
        step("sra_id", 6'b000000, 6'b000011, 1'b0, v_id());
        e = v_state(3'd2); e.alusrca = 1'b1; e.shift = 1'b1; e.aluc = 4'b1111;
        step("sra_exe", 6'b000000, 6'b000011, 1'b0, e);
        step("sra_wb", 6'b000000, 6'b000011, 1'b0, v_wb(1'b0, 1'b0));

        // ham
        step("ham_if", 6'b000000, 6'b111111, 1'b0, v_if());
        step("ham_id", 6'b000000, 6'b111111, 1'b0, v_id());
        e = v_state(3'd2); e.alusrca = 1'b1; e.aluc = 4'b1011;
        step("ham_exe", 6'b000000, 6'b111111, 1'b0, e);
        step("ham_wb", 6'b000000, 6'b111111, 1'b0, v_wb(1'b0, 1'b0));

        // beq taken / not taken, bne taken / not taken
        for (int i = 0; i < 4; i++) begin
            logic [5:0] bop;
            logic bz;
            bop = (i < 2) ? 6'b000100 : 6'b000101;
            bz  = (i % 2 == 0) ? 1'b1 : 1'b0;
            step("br_if", bop, 6'b010101, bz, v_if());
            step("br_id", bop, 6'b010101, bz, v_id());
            e = v_state(3'd2); e.aluc = 4'b0100; e.alusrca = 1'b1; e.pcsrc = 2'b01;
            e.wpc = (i == 0 || i == 3) ? 1'b1 : 1'b0;
            step(i < 2 ? (bz ? "beq_exe_z1" : "beq_exe_z0") : (bz ? "bne_exe_z1" : "bne_exe_z0"),
                 bop, 6'b010101, bz, e);
        end

        // lw with z high throughout (must be ignored)
        step("lw_if", 6'b100011, 6'b000000, 1'b1, v_if());
        step("lw_id", 6'b100011, 6'b000000, 1'b1, v_id());
        e = v_state(3'd2); e.alusrcb = 2'b10; e.sext = 1'b1;
        step("lw_exe", 6'b100011, 6'b000000, 1'b1, e);
        e = v_state(3'd3); e.iord = 1'b1;
        step("lw_mem", 6'b100011, 6'b000000, 1'b1, e);
        step("lw_wb", 6'b100011, 6'b000000, 1'b1, v_wb(1'b1, 1'b1));

        // sw
        step("sw_if", 6'b101011, 6'b000000, 1'b0, v_if());
        step("sw_id", 6'b101011, 6'b000000, 1'b0, v_id());
        e = v_state(3'd2); e.alusrcb = 2'b10; e.sext = 1'b1;
        step("sw_exe", 6'b101011, 6'b000000, 1'b0, e);
        e = v_state(3'd3); e.iord = 1'b1; e.wmem = 1'b1;
        step("sw_mem", 6'b101011, 6'b000000, 1'b0, e);

        // ori: zero-extended immediate, OR code, rt destination
        step("ori_if", 6'b001101, 6'b000000, 1'b0, v_if());
        step("ori_id", 6'b001101, 6'b000000, 1'b0, v_id());
        e = v_state(3'd2); e.alusrcb = 2'b10; e.aluc = 4'b0101;
        step("ori_exe", 6'b001101, 6'b000000, 1'b0, e);
        step("ori_wb", 6'b001101, 6'b000000, 1'b0, v_wb(1'b1, 1'b0));

        // jal
        step("jal_if", 6'b000011, 6'b000000, 1'b0, v_if());
        e = v_id(); e.wpc = 1'b1; e.pcsrc = 2'b11; e.jal = 1'b1; e.wreg = 1'b1;
        step("jal_id", 6'b000011, 6'b000000, 1'b0, e);

        // jr
        step("jr_if", 6'b000000, 6'b001000, 1'b0, v_if());
        e = v_id(); e.wpc = 1'b1; e.pcsrc = 2'b10;
        step("jr_id", 6'b000000, 6'b001000, 1'b0, e);

        // undefined op
        step("ill_if", 6'b111111, 6'b000000, 1'b0, v_if());
        e = v_id(); e.illegal = 1'b1;
        step("ill_id", 6'b111111, 6'b000000, 1'b0, e);
        step("ill_next_if", 6'b000000, 6'b100000, 1'b0, v_if());

        repeat (2) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle control unit for the team's MIPS-subset CPU.
- Decodes op/func, sequences IF/ID/EXE/MEM/WB, and drives the ALU's aluc code, datapath mux selects and write enables.
- This unit starts every ALU operation. The ALU executes it and returns z.
- It replaces the single-cycle decoder in the shared-memory multicycle datapath.

Parameters:
- PC_INC, 4, constant the ALU adds to PC in IF (alusrcb=01 path). Documents datapath intent only; the constant is not output.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces state to IF
- op  in  6  instruction [31:26], valid from ID onward (IR loaded at end of IF)
- func  in  6  instruction [5:0]
- z  in  1  ALU zero flag, combinational from the current-cycle ALU result
- wpc  out  1  PC write enable
- wir  out  1  IR write enable
- wmem  out  1  memory write enable
- wreg  out  1  register file write enable
- iord  out  1  memory address select: 0=PC, 1=ALU-out register
- aluc  out  4  ALU operation code
- alusrca  out  1  ALU A select: 0=PC, 1=register A
- shift  out  1  ALU A select override: 1=zero-extended sa (IR[10:6])
- alusrcb  out  2  ALU B select: 00=reg B, 01=PC_INC, 10=ext imm, 11=sext imm<<2
- sext  out  1  immediate extension: 1=sign, 0=zero
- pcsrc  out  2  PC source: 00=ALU result, 01=ALU-out register (branch target), 10=reg A (jr), 11=jump address
- regrt  out  1  destination select: 1=rt, 0=rd
- m2reg  out  1  write-back select: 1=MDR
- jal  out  1  forces destination to $31 and data to PC
- illegal  out  1  1-cycle pulse in ID when op/func is unsupported
- state  out  3  current state, for debug

Behaviour:
- Encodings:
  - States: IF=0, ID=1, EXE=2, MEM=3, WB=4. Codes 5–7 are unreachable; if entered, next state is IF and all write enables are 0.
  - aluc: ADD 0000, AND 0001, XOR 0010, SLL 0011, SUB 0100, OR 0101, LUI 0110, SRL 0111, HAM 1011, SRA 1111.
  - R-type (op 000000) funcs: add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000, ham 111111 (Hamming distance of rs, rt).
  - Other ops: addi 001000, andi 001100, ori 001101, xori 001110, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
- Timing:
  - The state register is the only flop.
  - All outputs are combinational from state, op, func and z.
  - Unlisted outputs are 0 in each state.
- IF:
  - iord=0, wir=1, alusrca=0, alusrcb=01, aluc=ADD, pcsrc=00, wpc=1.
  - Next state: ID.
- ID:
  - alusrca=0, alusrcb=11, sext=1, aluc=ADD. This latches the branch target.
  - j: pcsrc=11, wpc=1; next IF.
  - jal: additionally jal=1, wreg=1; next IF.
  - jr: pcsrc=10, wpc=1; next IF.
  - Unsupported op/func: illegal=1, no writes; next IF.
  - Otherwise: next EXE.
- EXE (aluc per table):
  - R-type: alusrca=1, alusrcb=00; shift=1 for sll/srl/sra.
  - I-type ALU ops and lw/sw: alusrcb=10. sext=1 for addi/lw/sw, 0 for andi/ori/xori/lui.
  - lw/sw use aluc=ADD.
  - beq/bne: aluc=SUB, alusrca=1, alusrcb=00, pcsrc=01. wpc=z for beq, wpc=~z for bne. Next IF.
  - lw/sw: next MEM. Others: next WB.
- MEM:
  - iord=1.
  - sw: wmem=1; next IF.
  - lw: next WB.
- WB:
  - wreg=1; regrt=1 for I-type; m2reg=1 for lw.
  - Next IF.
- Per-instruction cycle counts:
  - j, jal, jr, illegal: 2
  - beq, bne: 3
  - R-type and I-type ALU ops: 4
  - sw: 4
  - lw: 5
- Reset:
  - While reset=1: state=IF and wpc=wir=wmem=wreg=illegal=0. Other outputs show IF decode.
  - Reset asserted mid-instruction aborts it immediately; no partial write occurs in that cycle.
  - First IF write happens on the first rising clock edge after reset deasserts.
- z is sampled only in EXE for branches. It is ignored in every other state.

Decomposition:
- Shared package mips_defs:
  - opcode and func localparams
  - aluc codes, shared with the ALU
  - state encodings
  - alusrcb and pcsrc select codes
- One natural sub-module: mc_decode.
  - Combinational op/func → instruction class one-hots (rtype, itype_alu, load, store, branch, jump, illegal) plus exe_aluc.
  - mc_control keeps the state register and per-state output logic.

Test Plan:
- Reset held 3 cycles mid-EXE of add, then released: state reads 0 during reset, wreg never 1; next edge gives wir=1, wpc=1.
- add (op 000000, func 100000): states 0,1,2,4. EXE aluc=0000, alusrcb=00. WB wreg=1, regrt=0. Total 4 cycles.
- sra (func 000011): EXE aluc=1111, shift=1. ham (func 111111): EXE aluc=1011.
- beq with z=1: EXE wpc=1, pcsrc=01. Same instruction with z=0: wpc=0. Both return to IF after 3 cycles. bne inverts.
- lw: states 0,1,2,3,4; MEM iord=1, wmem=0; WB m2reg=1, regrt=1. sw: MEM wmem=1, then IF, 4 cycles.
- jal: ID has wpc=1, pcsrc=11, jal=1, wreg=1, then IF. Undefined op 111111: ID illegal=1 for one cycle, no writes, then IF.
